// File: rtl/spart_tx.sv
// spart_tx: SPART transmitter. One-byte holding buffer in front of an 8N1 shifter, LSB first.
// Latency: txd changes one clk after the enable that causes a transition; start bit follows the next enable after a write.
// Backpressure: tbr=0 while the holding buffer is full; writes seen with tbr=0 are dropped.
// Optional even parity bit between data and stop: define SPART_TX_PARITY_EN.
module spart_tx #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data,
  output logic       tbr,
  output logic       txd
);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [3:0] TLAST = 4'(TICKS_PER_BIT - 1);

  state_t     state, state_nxt;
  logic [7:0] buf_dat;
  logic       buf_full;
  logic [7:0] shifter, shift_nxt;
  logic [3:0] tick_cnt, tick_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic       txd_nxt;
  logic       wr, accept, load;
`ifdef SPART_TX_PARITY_EN
  logic       par, par_nxt;
`endif

  // A load empties the buffer in the same cycle, so a write racing the load is accepted.
  assign wr     = iocs & ~iorw & (ioaddr == 2'b00);
  assign load   = buf_full & enable &
                  ((state == IDLE) | ((state == STOP) & (tick_cnt == TLAST)));
  assign tbr    = ~buf_full | load;
  assign accept = wr & tbr;

  // Holding buffer: a new byte wins over the load-driven emptying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_dat  <= '0;
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_dat  <= data;
      buf_full <= 1'b1;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Frame state register and registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shifter  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      shifter  <= shift_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      txd      <= txd_nxt;
`ifdef SPART_TX_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  // Next-state: load, tick counting, bit advance, and the txd level of the next state.
  always_comb begin
    state_nxt = state;
    shift_nxt = shifter;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
`ifdef SPART_TX_PARITY_EN
    par_nxt   = par;
`endif
    if (load) begin
      state_nxt = START;
      shift_nxt = buf_dat;
      tick_nxt  = '0;
      bit_nxt   = '0;
`ifdef SPART_TX_PARITY_EN
      par_nxt   = ^buf_dat;
`endif
    end else if (enable && (state != IDLE)) begin
      if (tick_cnt == TLAST) begin
        tick_nxt = '0;
        case (state)
          START: state_nxt = DATA;
          DATA: begin
            shift_nxt = {1'b0, shifter[7:1]};
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
`ifdef SPART_TX_PARITY_EN
          PARITY: state_nxt = STOP;
`endif
          STOP:    state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end else begin
        tick_nxt = tick_cnt + 4'd1;
      end
    end

    txd_nxt = 1'b1;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
`ifdef SPART_TX_PARITY_EN
      PARITY:  txd_nxt = par_nxt;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed checks of spart_tx with enable every 4 clk and 16 ticks per bit.
// Frames are captured by sampling txd on every negedge and checking each bit window is flat.
// Parity expectations are selected when SPART_TX_PARITY_EN is defined.
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BITLEN = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] data = 8'h00;
  logic       tbr, txd;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  spart_tx #(.TICKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .data(data), .tbr(tbr), .txd(txd)
  );

  always #5 clk = ~clk;

  // Baud tick: one-clk pulse in every cycle whose number is a multiple of 4.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      enable = (cyc % 4 == 0);
    end
  end

  typedef struct {
    logic [7:0]  dat;
    logic [9:0]  e10;
    logic [10:0] e11;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [10:0] pick(input logic [9:0] e10, input logic [10:0] e11);
`ifdef SPART_TX_PARITY_EN
    return e11;
`else
    return {1'b0, e10};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    iocs = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic align(input int k);
    while (cyc % 4 != k) @(negedge clk);
  endtask

  // Bus write held for the cycle of the current negedge; returns one negedge later.
  task automatic put(input logic [7:0] b);
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; data = b;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  // Waits up to max_wait cycles for a start bit, then samples NB bit windows of BITLEN cycles.
  task automatic recv(input int max_wait, output logic [10:0] got, output logic found,
                      output logic stable, output int waited, output logic tbr_start);
    got = '0; found = 1'b0; stable = 1'b1; waited = 0; tbr_start = 1'b0;
    while (waited < max_wait) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      waited++;
    end
    if (found) begin
      tbr_start = tbr;
      for (int i = 0; i < NB; i++) begin
        for (int k = 0; k < BITLEN; k++) begin
          if (!(i == 0 && k == 0)) @(negedge clk);
          if (k == 0) got[i] = txd;
          else if (txd !== got[i]) stable = 1'b0;
        end
      end
    end
  endtask

  logic [10:0] g1, g2, g3;
  logic        f1, f2, f3, s1, s2, s3, t1, t2, t3;
  int          w1, w2, w3;

  initial begin
    // Transmission order is bit 0 first: start, d0..d7, [parity], stop.
    tbl[0] = '{8'hA5, 10'b1101001010, 11'b10101001010};
    tbl[1] = '{8'h07, 10'b1000001110, 11'b11000001110};
    tbl[2] = '{8'h03, 10'b1000000110, 11'b10000000110};
    tbl[3] = '{8'hFF, 10'b1111111110, 11'b10111111110};

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_tbr", 32'(tbr), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Writes to other addresses and reads do not touch the buffer.
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b01; data = 8'h55;
    @(negedge clk);
    iorw = 1'b1; ioaddr = 2'b00;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
    @(negedge clk);
    chk("nondecoded_tbr", 32'(tbr), 32'd1);
    repeat (12) @(negedge clk);
    chk("nondecoded_txd", 32'(txd), 32'd1);

    // Single frames from the table.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      align(1);
      put(tbl[v].dat);
      chk($sformatf("tbr_after_wr[%0d]", v), 32'(tbr), 32'd0);
      chk($sformatf("txd_idle_wr[%0d]", v), 32'(txd), 32'd1);
      recv(20, g1, f1, s1, w1, t1);
      chk($sformatf("found[%0d]", v), 32'(f1), 32'd1);
      chk($sformatf("start_lat[%0d]", v), 32'(w1), 32'd2);
      chk($sformatf("tbr_at_start[%0d]", v), 32'(t1), 32'd1);
      chk($sformatf("frame[%0d]", v), 32'(g1), 32'(pick(tbl[v].e10, tbl[v].e11)));
      chk($sformatf("bit_len[%0d]", v), 32'(s1), 32'd1);
      repeat (8) @(negedge clk);
      chk($sformatf("idle_txd[%0d]", v), 32'(txd), 32'd1);
      chk($sformatf("idle_tbr[%0d]", v), 32'(tbr), 32'd1);
    end

    // Back-to-back: second byte written as soon as tbr rises.
    do_reset();
    align(1);
    put(8'h00);
    fork
      begin
        int t;
        t = 0;
        while (tbr !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("b2b_tbr_wait", 32'(t < 100), 32'd1);
        put(8'hFF);
      end
      begin
        recv(20, g1, f1, s1, w1, t1);
        recv(1, g2, f2, s2, w2, t2);
      end
    join
    chk("b2b_frame1", 32'(g1), 32'(pick(10'b1000000000, 11'b10000000000)));
    chk("b2b_found2", 32'(f2), 32'd1);
    chk("b2b_gap", 32'(w2), 32'd0);
    chk("b2b_frame2", 32'(g2), 32'(pick(10'b1111111110, 11'b10111111110)));

    // Overrun: 11 accepted, 22 accepted in the load cycle, 33 dropped.
    do_reset();
    align(3);
    fork
      begin
        put(8'h11);
        put(8'h22);
        chk("ovr_tbr_at_33", 32'(tbr), 32'd0);
        put(8'h33);
      end
      begin
        recv(20, g1, f1, s1, w1, t1);
        recv(1, g2, f2, s2, w2, t2);
        recv(900, g3, f3, s3, w3, t3);
      end
    join
    chk("ovr_frame1", 32'(g1), 32'(pick(10'b1000100010, 11'b10000100010)));
    chk("ovr_frame2", 32'(g2), 32'(pick(10'b1001000100, 11'b10001000100)));
    chk("ovr_no_third", 32'(f3), 32'd0);

    // Load of C3 and write of 5A in the same cycle.
    do_reset();
    align(3);
    fork
      begin
        put(8'hC3);
        chk("sim_tbr_load_cycle", 32'(tbr), 32'd1);
        put(8'h5A);
        chk("sim_tbr_after", 32'(tbr), 32'd0);
        @(negedge clk);
        chk("sim_tbr_held", 32'(tbr), 32'd0);
      end
      begin
        recv(20, g1, f1, s1, w1, t1);
        recv(1, g2, f2, s2, w2, t2);
      end
    join
    chk("sim_frame1", 32'(g1), 32'(pick(10'b1110000110, 11'b10110000110)));
    chk("sim_gap", 32'(w2), 32'd0);
    chk("sim_frame2", 32'(g2), 32'(pick(10'b1010110100, 11'b10010110100)));

    // Reset in data bit 3 with a second byte buffered.
    do_reset();
    align(1);
    put(8'hA5);
    w1 = 0;
    while (txd !== 1'b0 && w1 < 20) begin
      @(negedge clk);
      w1++;
    end
    chk("rstmid_started", 32'(w1 < 20), 32'd1);
    put(8'hB7);
    chk("rstmid_buf_full", 32'(tbr), 32'd0);
    repeat (4 * BITLEN + 20 - 1) @(negedge clk);
    chk("rstmid_bit3", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_txd", 32'(txd), 32'd1);
    chk("rstmid_tbr", 32'(tbr), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    recv(800, g1, f1, s1, w1, t1);
    chk("rstmid_no_frame", 32'(f1), 32'd0);
    chk("rstmid_tbr_after", 32'(tbr), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
